ctrl_seq_16b: RTL and testbench

Multi-cycle control sequencer for the 16-bit datapath. It accepts one instruction word per valid/ready handshake and decodes it. It then drives the per-register `load`/`outenA`/`outenB` strobes of the eight `reg_16b` instances and the start/done handshake of the downstream ALU. It sits directly upstream of the register bank and owns all register-file control.

---
 rtl/ctrl_seq_16b.sv | 121 ++++++++++++
 tb/tb_ctrl_seq_16b.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_seq_16b.sv
// rtl/ctrl_seq_16b.sv - multi-cycle register-file/ALU control sequencer
// Strobes decode from state and IR only, so an async reset clears them at once.
module ctrl_seq_16b #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic        alu_done,
  output logic [7:0]  load,
  output logic [7:0]  outenA,
  output logic [7:0]  outenB,
  output logic [3:0]  alu_op,
  output logic        alu_start,
  output logic        wb_sel,
  output logic [15:0] imm,
  output logic        halted,
  output logic        err,
  output logic [15:0] retire_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_DECODE, S_READ, S_EXEC, S_WB, S_HALT
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_MOV  = 4'd6;
  localparam logic [3:0] OP_LDI  = 4'd7;
  localparam logic [3:0] OP_HALT = 4'd15;
  localparam logic [7:0] TLAST   = 8'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [15:0] ir;
  logic [7:0]  tcnt;
  logic        set_err, retire_inc;

  logic [3:0] op;
  logic [2:0] rd, ra, rb;
  assign op = ir[15:12];
  assign rd = ir[11:9];
  assign ra = ir[8:6];
  assign rb = ir[5:3];

  always_comb begin
    state_nxt   = state;
    set_err     = 1'b0;
    retire_inc  = 1'b0;
    instr_ready = 1'b0;
    load        = 8'h00;
    outenA      = 8'h00;
    outenB      = 8'h00;
    alu_op      = 4'd0;
    alu_start   = 1'b0;
    wb_sel      = 1'b0;
    case (state)
      S_IDLE: begin
        instr_ready = ~rst;
        if (instr_valid) state_nxt = S_DECODE;
      end
      S_DECODE: begin
        if (op == OP_NOP) begin
          retire_inc = 1'b1;
          state_nxt  = S_IDLE;
        end else if (op == OP_HALT) begin
          state_nxt = S_HALT;
        end else if (op == OP_LDI) begin
          state_nxt = S_WB;
        end else if (op <= OP_MOV) begin
          state_nxt = S_READ;
        end else begin
          set_err   = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_READ, S_EXEC: begin
        outenA    = 8'h01 << ra;
        outenB    = (op == OP_MOV) ? 8'h00 : (8'h01 << rb);
        alu_op    = (op == OP_MOV) ? 4'd0 : op;
        alu_start = (state == S_READ);
        if (state == S_READ) begin
          state_nxt = S_EXEC;
        end else if (alu_done) begin
          state_nxt = S_WB;
        end else if (tcnt == TLAST) begin
          set_err   = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_WB: begin
        load       = 8'h01 << rd;
        wb_sel     = (op != OP_LDI);
        retire_inc = 1'b1;
        state_nxt  = S_IDLE;
      end
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      ir         <= 16'h0000;
      tcnt       <= 8'd0;
      err        <= 1'b0;
      retire_cnt <= 16'h0000;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && instr_valid) ir <= instr;
      tcnt <= (state == S_EXEC) ? tcnt + 8'd1 : 8'd0;
      if (set_err) err <= 1'b1;
      if (retire_inc) retire_cnt <= retire_cnt + 16'h0001;
    end
  end

  assign imm    = {7'b0, ir[8:0]};
  assign halted = (state == S_HALT);

endmodule

// File: tb/tb_ctrl_seq_16b.sv
// tb/tb_ctrl_seq_16b.sv - directed and randomized bench for ctrl_seq_16b
module tb_ctrl_seq_16b;

  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        alu_done;
  logic [7:0]  load, outenA, outenB;
  logic [3:0]  alu_op;
  logic        alu_start, wb_sel, halted, err;
  logic [15:0] imm, retire_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] exp_retire;
  logic        exp_err;

  ctrl_seq_16b #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .alu_done(alu_done), .load(load),
    .outenA(outenA), .outenB(outenB), .alu_op(alu_op), .alu_start(alu_start),
    .wb_sel(wb_sel), .imm(imm), .halted(halted), .err(err),
    .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Transaction-level model: k = cycles from alu_start to alu_done, 0 = never.
  task automatic exec_instr(input logic [15:0] w, input int k);
    logic [3:0] op;
    logic [7:0] ea, eb, el;
    int guard;
    bit done;
    op = w[15:12];
    ea = 8'h01 << w[8:6];
    eb = (op == 4'd6) ? 8'h00 : (8'h01 << w[5:3]);
    el = 8'h01 << w[11:9];
    guard = 0;
    while (instr_ready !== 1'b1 && guard < 50) begin
      alu_done = 1'($urandom);
      tick();
      guard++;
    end
    chk("ready_wait", {31'b0, instr_ready}, 32'd1);
    instr = w;
    instr_valid = 1'b1;
    alu_done = 1'($urandom);
    tick();
    instr_valid = 1'b0;
    instr = 16'($urandom);
    alu_done = 1'($urandom);
    chk("decode_ready", {31'b0, instr_ready}, 32'd0);
    chk("decode_strobes", {load, outenA, outenB, 7'b0, alu_start}, 32'd0);
    tick();
    if (op == 4'd0) begin
      exp_retire++;
      chk("nop_ready", {31'b0, instr_ready}, 32'd1);
      chk("nop_retire", retire_cnt, exp_retire);
    end else if (op == 4'd15) begin
      chk("halt_flag", {31'b0, halted}, 32'd1);
      chk("halt_ready", {31'b0, instr_ready}, 32'd0);
    end else if (op >= 4'd8) begin
      exp_err = 1'b1;
      chk("ill_ready", {31'b0, instr_ready}, 32'd1);
      chk("ill_err", {31'b0, err}, 32'd1);
      chk("ill_retire", retire_cnt, exp_retire);
      chk("ill_load", load, 8'h00);
    end else if (op == 4'd7) begin
      chk("ldi_load", load, el);
      chk("ldi_wbsel", {31'b0, wb_sel}, 32'd0);
      chk("ldi_imm", imm, {7'b0, w[8:0]});
      chk("ldi_outen", {outenA, outenB}, 16'h0000);
      tick();
      exp_retire++;
      chk("ldi_ready", {31'b0, instr_ready}, 32'd1);
      chk("ldi_retire", retire_cnt, exp_retire);
    end else begin
      chk("read_outenA", outenA, ea);
      chk("read_outenB", outenB, eb);
      chk("read_aluop", alu_op, (op == 4'd6) ? 4'd0 : op);
      chk("read_start", {31'b0, alu_start}, 32'd1);
      chk("read_load", load, 8'h00);
      done = 1'b0;
      for (int j = 1; j <= TIMEOUT && !done; j++) begin
        tick();
        alu_done = (j == k);
        chk("exec_hold", {outenA, outenB, 4'b0, alu_op, 7'b0, alu_start},
            {ea, eb, 4'b0, (op == 4'd6) ? 4'd0 : op, 8'h00});
        chk("exec_quiet", {load, 7'b0, instr_ready}, 16'h0000);
        if (j == k) done = 1'b1;
      end
      tick();
      alu_done = 1'($urandom);
      if (done) begin
        chk("wb_load", load, el);
        chk("wb_sel", {31'b0, wb_sel}, 32'd1);
        chk("wb_outen", {outenA, outenB}, 16'h0000);
        tick();
        exp_retire++;
        chk("alu_ready", {31'b0, instr_ready}, 32'd1);
        chk("alu_retire", retire_cnt, exp_retire);
      end else begin
        exp_err = 1'b1;
        chk("to_ready", {31'b0, instr_ready}, 32'd1);
        chk("to_err", {31'b0, err}, 32'd1);
        chk("to_strobes", {load, outenA, outenB}, 24'h0);
        chk("to_retire", retire_cnt, exp_retire);
      end
    end
    chk("err_sticky", {31'b0, err}, {31'b0, exp_err});
  endtask

  initial begin
    logic [3:0] op;
    rst = 1'b1;
    instr = 16'h0000;
    instr_valid = 1'b0;
    alu_done = 1'b0;
    exp_retire = 16'h0000;
    exp_err = 1'b0;
    #1;
    chk("rst_ready", {31'b0, instr_ready}, 32'd0);
    chk("rst_outputs", {load, outenA, outenB, alu_op, 3'b0, alu_start}, 32'h0);
    chk("rst_misc", {imm, 13'b0, wb_sel, halted, err}, 32'h0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rel_ready", {31'b0, instr_ready}, 32'd1);
    chk("rel_retire", retire_cnt, 16'h0000);

    exec_instr({4'd7, 3'd3, 9'h1A5}, 0);
    exec_instr({4'd1, 3'd1, 3'd2, 3'd5, 3'd0}, 2);
    exec_instr({4'd6, 3'd0, 3'd7, 3'd0, 3'd0}, 1);
    exec_instr(16'hA123, 0);
    exec_instr({4'd2, 3'd4, 3'd6, 3'd6, 3'd0}, TIMEOUT);
    exec_instr({4'd1, 3'd2, 3'd3, 3'd3, 3'd0}, 0);
    exec_instr({4'd0, 12'hFFF}, 0);

    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 10));
      exec_instr({op, 12'($urandom)},
                 ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 6)));
    end

    exec_instr(16'hF000, 0);
    instr_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      instr = 16'($urandom);
      alu_done = 1'($urandom);
      tick();
      if (i % 5 == 4) begin
        chk("halt_hold", {halted, instr_ready}, 2'b10);
        chk("halt_strobes", {load, outenA, outenB, 7'b0, alu_start}, 32'h0);
      end
    end
    instr_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("halt_rst", {31'b0, halted}, 32'd0);
    tick();
    rst = 1'b0;
    exp_retire = 16'h0000;
    exp_err = 1'b0;
    #1;

    instr = {4'd4, 3'd5, 3'd1, 3'd2, 3'd0};
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    alu_done = 1'b0;
    tick();
    tick();
    tick();
    chk("mid_exec_en", outenA, 8'h02);
    #3;
    rst = 1'b1;
    #1;
    chk("mid_rst_strobes", {load, outenA, outenB, alu_op, 3'b0, alu_start}, 32'h0);
    chk("mid_rst_ready", {31'b0, instr_ready}, 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("mid_rst_retire", retire_cnt, 16'h0000);
    chk("mid_rst_ready2", {31'b0, instr_ready}, 32'd1);
    exec_instr({4'd5, 3'd7, 3'd0, 3'd0, 3'd0}, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
